// File: rtl/dcache_evict_buffer.sv
// Write-back eviction buffer between the L1 data cache and downstream memory.
// Optional read forwarding from buffered lines is enabled by defining DCACHE_EVICT_FWD_EN.
module dcache_evict_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  l1_address,
    input  logic         l1_read,
    input  logic         l1_write,
    input  logic [127:0] l1_wdata,
    output logic [127:0] l1_rdata,
    output logic         l1_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic         buf_empty,
    output logic         buf_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, RESP} state_e;

    state_e             state_q, state_d;
    logic               valid_q [DEPTH];
    logic [11:0]        tag_q   [DEPTH];
    logic [127:0]       data_q  [DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [127:0]       rdata_q;

    logic [11:0]        reqTag;
    logic               hit;
    logic [PTR_W-1:0]   hitIdx;
    logic               full, empty;
    logic               push, coalesce, pop, latchMem;
`ifdef DCACHE_EVICT_FWD_EN
    logic               latchFwd;
`endif
    logic               unusedAddrBits;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign reqTag         = l1_address[15:4];
    assign unusedAddrBits = ^l1_address[3:0];
    assign full           = (count_q == CNT_W'(DEPTH));
    assign empty          = (count_q == '0);

    // Coalescing keeps at most one entry per tag, so the last match is the only match.
    always_comb begin
        hit    = 1'b0;
        hitIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == reqTag)) begin
                hit    = 1'b1;
                hitIdx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        coalesce = 1'b0;
        pop      = 1'b0;
        latchMem = 1'b0;
`ifdef DCACHE_EVICT_FWD_EN
        latchFwd = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (l1_write) begin
                    if (hit) begin
                        coalesce = 1'b1;
                        state_d  = RESP;
                    end else if (!full) begin
                        push    = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WR_MEM;
                    end
                end else if (l1_read) begin
                    if (!hit) begin
                        state_d = RD_MEM;
                    end else begin
`ifdef DCACHE_EVICT_FWD_EN
                        latchFwd = 1'b1;
                        state_d  = RESP;
`else
                        // Drain from the head until the requested line has reached memory.
                        state_d = WR_MEM;
`endif
                    end
                end else if (!empty) begin
                    state_d = WR_MEM;
                end
            end
            RD_MEM: begin
                if (pmem_resp) begin
                    latchMem = 1'b1;
                    state_d  = RESP;
                end
            end
            WR_MEM: begin
                if (pmem_resp) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tag_q[tail_q]   <= reqTag;
                data_q[tail_q]  <= l1_wdata;
                tail_q          <= ptrInc(tail_q);
                count_q         <= count_q + 1'b1;
            end
            if (coalesce) data_q[hitIdx] <= l1_wdata;
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptrInc(head_q);
                count_q         <= count_q - 1'b1;
            end
            if (latchMem) rdata_q <= pmem_rdata;
`ifdef DCACHE_EVICT_FWD_EN
            else if (latchFwd) rdata_q <= data_q[hitIdx];
`endif
        end
    end

    always_comb begin
        pmem_read    = (state_q == RD_MEM);
        pmem_write   = (state_q == WR_MEM);
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state_q == WR_MEM) begin
            pmem_address = {tag_q[head_q], 4'b0};
            pmem_wdata   = data_q[head_q];
        end else if (state_q == RD_MEM) begin
            pmem_address = {reqTag, 4'b0};
        end
    end

    assign l1_resp   = (state_q == RESP);
    assign l1_rdata  = rdata_q;
    assign buf_empty = empty;
    assign buf_full  = full;

endmodule

// File: tb/tb_dcache_evict_buffer.sv
// Directed self-checking bench for dcache_evict_buffer (DEPTH=4).
// Covers both builds of DCACHE_EVICT_FWD_EN for the buffered-read case.
module tb_dcache_evict_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  l1_address;
    logic         l1_read;
    logic         l1_write;
    logic [127:0] l1_wdata;
    logic [127:0] l1_rdata;
    logic         l1_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         buf_empty;
    logic         buf_full;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] D1 = 128'hD1D1_0001_D1D1_0002_D1D1_0003_D1D1_0004;
    localparam logic [127:0] D2 = 128'hD2D2_1111_D2D2_2222_D2D2_3333_D2D2_4444;
    localparam logic [127:0] D3 = 128'hD3D3_ABCD_D3D3_ABCD_D3D3_ABCD_D3D3_ABCD;
    localparam logic [127:0] R1 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [127:0] R2 = 128'hCAFE_F00D_CAFE_F00D_BEEF_0000_BEEF_1111;

    dcache_evict_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l1_address   (l1_address),
        .l1_read      (l1_read),
        .l1_write     (l1_write),
        .l1_wdata     (l1_wdata),
        .l1_rdata     (l1_rdata),
        .l1_resp      (l1_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] lineData(input logic [15:0] a);
        return {8{a}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [127:0] wdata);
        l1_read    = rd;
        l1_write   = wr;
        l1_address = addr;
        l1_wdata   = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Starts in IDLE with a nonempty buffer: one cycle to WR_MEM, then complete the drain.
    task automatic drainOne(input logic [15:0] expAddr, input logic [127:0] expData, input string tag);
        tick();
        checkOutput({tag, "_pmem_write"}, pmem_write, 1'b1);
        checkOutput({tag, "_addr"}, pmem_address, expAddr);
        checkOutput({tag, "_wdata"}, pmem_wdata, expData);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        checkOutput({tag, "_write_done"}, pmem_write, 1'b0);
    endtask

    task automatic writeLine(input logic [15:0] addr, input logic [127:0] data, input string tag);
        applyStimulus(1'b0, 1'b1, addr, data);
        tick();
        checkOutput({tag, "_resp"}, l1_resp, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 128'h0);
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0, 128'h0);
        tick();
        tick();
        checkOutput("rst_l1_resp", l1_resp, 1'b0);
        checkOutput("rst_l1_rdata", l1_rdata, 128'h0);
        checkOutput("rst_pmem_read", pmem_read, 1'b0);
        checkOutput("rst_pmem_write", pmem_write, 1'b0);
        checkOutput("rst_pmem_address", pmem_address, 16'h0);
        checkOutput("rst_pmem_wdata", pmem_wdata, 128'h0);
        checkOutput("rst_buf_empty", buf_empty, 1'b1);
        checkOutput("rst_buf_full", buf_full, 1'b0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single writeback and background drain");
        applyStimulus(1'b0, 1'b1, 16'h1230, D1);
        tick();
        checkOutput("wb_resp", l1_resp, 1'b1);
        checkOutput("wb_not_empty", buf_empty, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 128'h0);
        tick();
        checkOutput("wb_idle_no_write", pmem_write, 1'b0);
        drainOne(16'h1230, D1, "wb_drain");
        checkOutput("wb_empty_after", buf_empty, 1'b1);

        $display("[TB] fill to full, stalled write, wrap");
        for (int i = 0; i < 4; i++) begin
            writeLine(16'h1000 + 16'(i * 16), lineData(16'h1000 + 16'(i * 16)), "fill");
        end
        checkOutput("fill_full", buf_full, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h1040, lineData(16'h1040));
        tick();
        checkOutput("full_drain_write", pmem_write, 1'b1);
        checkOutput("full_drain_addr", pmem_address, 16'h1000);
        checkOutput("full_no_resp", l1_resp, 1'b0);
        tick();
        tick();
        checkOutput("full_hold_write", pmem_write, 1'b1);
        checkOutput("full_hold_addr", pmem_address, 16'h1000);
        checkOutput("full_hold_data", pmem_wdata, lineData(16'h1000));
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        checkOutput("full_after_pop", buf_full, 1'b0);
        checkOutput("full_still_waiting", l1_resp, 1'b0);
        tick();
        checkOutput("stalled_write_resp", l1_resp, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 128'h0);
        tick();
        checkOutput("refull", buf_full, 1'b1);
        for (int i = 1; i < 5; i++) begin
            drainOne(16'h1000 + 16'(i * 16), lineData(16'h1000 + 16'(i * 16)), "wrap_drain");
        end
        checkOutput("wrap_empty", buf_empty, 1'b1);

        $display("[TB] coalescing writes to the same line");
        writeLine(16'h2000, D1, "coal1");
        writeLine(16'h2000, D2, "coal2");
        checkOutput("coal_not_empty", buf_empty, 1'b0);
        drainOne(16'h2000, D2, "coal_drain");
        checkOutput("coal_single_entry", buf_empty, 1'b1);

        $display("[TB] read miss passes through");
        applyStimulus(1'b1, 1'b0, 16'h3005, 128'h0);
        tick();
        checkOutput("rd_pmem_read", pmem_read, 1'b1);
        checkOutput("rd_addr_aligned", pmem_address, 16'h3000);
        checkOutput("rd_no_resp_yet", l1_resp, 1'b0);
        pmem_rdata = R1;
        pmem_resp  = 1'b1;
        tick();
        pmem_resp = 1'b0;
        checkOutput("rd_resp", l1_resp, 1'b1);
        checkOutput("rd_data", l1_rdata, R1);
        checkOutput("rd_pmem_released", pmem_read, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 128'h0);
        tick();
        checkOutput("rd_resp_one_cycle", l1_resp, 1'b0);

        $display("[TB] read of a buffered line");
        writeLine(16'h4000, D3, "buf4000");
        applyStimulus(1'b1, 1'b0, 16'h4000, 128'h0);
        tick();
`ifdef DCACHE_EVICT_FWD_EN
        checkOutput("fwd_resp", l1_resp, 1'b1);
        checkOutput("fwd_data", l1_rdata, D3);
        checkOutput("fwd_no_pmem_read", pmem_read, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 128'h0);
        tick();
        checkOutput("fwd_still_buffered", buf_empty, 1'b0);
        drainOne(16'h4000, D3, "fwd_drain");
`else
        checkOutput("hold_write_first", pmem_write, 1'b1);
        checkOutput("hold_write_addr", pmem_address, 16'h4000);
        checkOutput("hold_write_data", pmem_wdata, D3);
        checkOutput("hold_no_read", pmem_read, 1'b0);
        checkOutput("hold_no_resp", l1_resp, 1'b0);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        checkOutput("hold_drained", buf_empty, 1'b1);
        tick();
        checkOutput("hold_then_read", pmem_read, 1'b1);
        checkOutput("hold_read_addr", pmem_address, 16'h4000);
        checkOutput("hold_read_no_write", pmem_write, 1'b0);
        pmem_rdata = R2;
        pmem_resp  = 1'b1;
        tick();
        pmem_resp = 1'b0;
        checkOutput("hold_resp", l1_resp, 1'b1);
        checkOutput("hold_data", l1_rdata, R2);
        applyStimulus(1'b0, 1'b0, 16'h0, 128'h0);
        tick();
`endif
        checkOutput("buf_read_empty_end", buf_empty, 1'b1);

        $display("[TB] reset during drain");
        writeLine(16'h5000, D1, "rst5000");
        tick();
        checkOutput("pre_rst_write", pmem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_pmem_write", pmem_write, 1'b0);
        checkOutput("arst_pmem_address", pmem_address, 16'h0);
        checkOutput("arst_pmem_wdata", pmem_wdata, 128'h0);
        checkOutput("arst_l1_rdata", l1_rdata, 128'h0);
        checkOutput("arst_l1_resp", l1_resp, 1'b0);
        checkOutput("arst_buf_empty", buf_empty, 1'b1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("post_rst_no_write", pmem_write, 1'b0);
            checkOutput("post_rst_empty", buf_empty, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
